bbox_uart_tx: RTL and testbench



---
 rtl/bbox_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_bbox_uart_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bbox_uart_tx.sv
// bbox_uart_tx: snapshots the motion bounding box once per detection frame
// and serialises it as a fixed 12-byte 8N1 packet on uart_txd.
// Packet: A5 5A flags xmin_hi xmin_lo xmax_hi xmax_lo ymin_hi ymin_lo
//         ymax_hi ymax_lo checksum, with flags = {seq[6:0], valid} and the
//         checksum being the mod-256 sum of bytes 2..10.
module bbox_uart_tx #(
  parameter int CLK_FREQ     = 30_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic        clk_vga,
  input  logic        sys_rst_n,
  input  logic        frame_done,
  input  logic [11:0] xpos_min,
  input  logic [11:0] xpos_max,
  input  logic [11:0] ypos_min,
  input  logic [11:0] ypos_max,
  output logic        uart_txd,
  output logic        busy,
  output logic        pkt_sent,
  output logic        overrun,
  output logic [7:0]  drop_cnt
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BYTE = 4'd11;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_idx_q;
  logic [3:0]       byte_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       chk_q;
  logic [7:0]       flags_q;
  logic [6:0]       seq_q;
  logic [11:0]      xmin_q, xmax_q, ymin_q, ymax_q;
  logic             txd_q, busy_q, pkt_sent_q, overrun_q;
  logic [7:0]       drop_cnt_q;

  logic [3:0]       next_idx_d;
  logic [7:0]       next_byte_d;
  logic             bit_end;
  logic             valid_d;

  assign bit_end = (baud_q == BIT_LAST);
  assign valid_d = (xpos_max >= xpos_min) && (ypos_max >= ypos_min);

  // Select the byte that follows the one currently on the line, taken from
  // the latched snapshot (never the live inputs).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    next_idx_d  = byte_idx_q + 4'd1;
    next_byte_d = 8'hA5;
    case (next_idx_d)
      4'd1:    next_byte_d = 8'h5A;
      4'd2:    next_byte_d = flags_q;
      4'd3:    next_byte_d = {4'h0, xmin_q[11:8]};
      4'd4:    next_byte_d = xmin_q[7:0];
      4'd5:    next_byte_d = {4'h0, xmax_q[11:8]};
      4'd6:    next_byte_d = xmax_q[7:0];
      4'd7:    next_byte_d = {4'h0, ymin_q[11:8]};
      4'd8:    next_byte_d = ymin_q[7:0];
      4'd9:    next_byte_d = {4'h0, ymax_q[11:8]};
      4'd10:   next_byte_d = ymax_q[7:0];
      4'd11:   next_byte_d = chk_q;
      default: next_byte_d = 8'hA5;
    endcase
  end

  // Packet FSM with registered line, status pulses and drop accounting.
  always_ff @(posedge clk_vga or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // NOTE: the snapshot registers are reset too; they are plain flops, not
      // a memory, so the reset costs nothing and keeps simulation X-free.
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      chk_q      <= '0;
      flags_q    <= '0;
      seq_q      <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      pkt_sent_q <= 1'b0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge register values regardless of statement order.
      pkt_sent_q <= 1'b0;
      overrun_q  <= 1'b0;

      // A strobe arriving while a packet is in flight is dropped untouched.
      if (frame_done && busy_q) begin
        overrun_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (frame_done) begin
            xmin_q     <= xpos_min;
            xmax_q     <= xpos_max;
            ymin_q     <= ypos_min;
            ymax_q     <= ypos_max;
            flags_q    <= {seq_q, valid_d};
            seq_q      <= seq_q + 7'd1;
            chk_q      <= '0;
            byte_idx_q <= '0;
            shift_q    <= 8'hA5;
            baud_q     <= '0;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (byte_idx_q == LAST_BYTE) begin
              busy_q     <= 1'b0;
              pkt_sent_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              byte_idx_q <= next_idx_d;
              shift_q    <= next_byte_d;
              if (next_idx_d >= 4'd2 && next_idx_d <= 4'd10)
                chk_q <= chk_q + next_byte_d;
              txd_q   <= 1'b0;
              state_q <= S_START;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign uart_txd = txd_q;
  assign busy     = busy_q;
  assign pkt_sent = pkt_sent_q;
  assign overrun  = overrun_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bbox_uart_tx.sv
// tb_bbox_uart_tx: directed bench for bbox_uart_tx. A reduced baud divider
// (1000/77 truncates to 12 clocks per bit) keeps packets short; every cycle
// of each packet is compared against the hand-written byte list.
module tb_bbox_uart_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 77;
  localparam int CPB      = 12;          // 1000/77 = 12.98, truncated
  localparam int PKT      = 120 * CPB;   // cycles per packet

  logic        clk_vga = 1'b0;
  logic        sys_rst_n;
  logic        frame_done;
  logic [11:0] xpos_min, xpos_max, ypos_min, ypos_max;
  logic        uart_txd, busy, pkt_sent, overrun;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk_vga = ~clk_vga;

  bbox_uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk_vga   (clk_vga),
    .sys_rst_n (sys_rst_n),
    .frame_done(frame_done),
    .xpos_min  (xpos_min),
    .xpos_max  (xpos_max),
    .ypos_min  (ypos_min),
    .ypos_max  (ypos_max),
    .uart_txd  (uart_txd),
    .busy      (busy),
    .pkt_sent  (pkt_sent),
    .overrun   (overrun),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drop strobes are issued in cycles 5, 5+gap, 5+2*gap, ...
  function automatic logic is_drop(input int k, input int n, input int gap);
    if (n == 0 || k < 5) return 1'b0;
    return ((k - 5) % gap == 0) && ((k - 5) / gap < n);
  endfunction

  // Expected line level for bit slot j of a packet (byte 0 in exp[95:88]).
  function automatic logic stream_bit(input logic [95:0] exp, input int j);
    logic [7:0] b;
    int         pos;
    b   = exp[95 - 8 * (j / 10) -: 8];
    pos = j % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos - 1];
  endfunction

  // Strobe one frame in the current cycle and follow the whole packet.
  // Returns in the cycle where pkt_sent is expected high.
  task automatic run_packet(input string name,
                            input logic [11:0] x0, input logic [11:0] x1,
                            input logic [11:0] y0, input logic [11:0] y1,
                            input logic [95:0] exp, input int n_drops, input int gap);
    logic [119:0] rx;
    logic [7:0]   got;
    int           bit_err, flag_err, ovr_err, n_ovr;
    bit_err = 0; flag_err = 0; ovr_err = 0; n_ovr = 0; rx = '0;
    check({name, " idle_txd_before"}, uart_txd, 1'b1);
    check({name, " idle_busy_before"}, busy, 1'b0);
    xpos_min = x0; xpos_max = x1; ypos_min = y0; ypos_max = y1;
    frame_done = 1'b1;
    @(posedge clk_vga); #1;
    for (int k = 1; k <= PKT; k++) begin
      if (uart_txd !== stream_bit(exp, (k - 1) / CPB)) bit_err++;
      if (busy !== 1'b1 || pkt_sent !== 1'b0) flag_err++;
      if (overrun !== is_drop(k - 1, n_drops, gap)) ovr_err++;
      if (overrun === 1'b1) n_ovr++;
      if ((k - 1) % CPB == CPB / 2) rx[(k - 1) / CPB] = uart_txd;
      frame_done = is_drop(k, n_drops, gap);
      if (frame_done) begin
        xpos_min = 12'($urandom); xpos_max = 12'($urandom);
        ypos_min = 12'($urandom); ypos_max = 12'($urandom);
      end
      @(posedge clk_vga); #1;
    end
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < 8; i++) got[i] = rx[b * 10 + 1 + i];
      check($sformatf("%s byte%0d", name, b), got, exp[95 - 8 * b -: 8]);
    end
    check({name, " bit_errors"}, bit_err, 0);
    check({name, " busy_errors"}, flag_err, 0);
    check({name, " overrun_timing_errors"}, ovr_err, 0);
    check({name, " overrun_pulses"}, n_ovr, n_drops);
    check({name, " pkt_sent"}, pkt_sent, 1'b1);
    check({name, " busy_after"}, busy, 1'b0);
    check({name, " txd_after"}, uart_txd, 1'b1);
  endtask

  task automatic idle_cycle(input string name);
    @(posedge clk_vga); #1;
    check({name, " pkt_sent_cleared"}, pkt_sent, 1'b0);
    check({name, " txd_idle"}, uart_txd, 1'b1);
    check({name, " busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    sys_rst_n = 1'b0; frame_done = 1'b0;
    xpos_min = '0; xpos_max = '0; ypos_min = '0; ypos_max = '0;
    #25;
    check("reset txd", uart_txd, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset pkt_sent", pkt_sent, 1'b0);
    check("reset overrun", overrun, 1'b0);
    check("reset drop_cnt", drop_cnt, 8'd0);
    @(negedge clk_vga) sys_rst_n = 1'b1;
    @(posedge clk_vga); #1;

    // Nominal box, seq 0, valid.
    run_packet("nominal", 12'd100, 12'd300, 12'd50, 12'd200,
               96'hA5_5A_01_00_64_01_2C_00_32_00_C8_8C, 0, 1);
    idle_cycle("nominal");

    // Inverted box, seq 1, invalid.
    run_packet("invalid", 12'd640, 12'd0, 12'd480, 12'd0,
               96'hA5_5A_02_02_80_00_00_01_E0_00_00_65, 0, 1);
    idle_cycle("invalid");

    // Three drops mid-packet; seq 2, content unchanged by the drops.
    run_packet("overrun", 12'd100, 12'd300, 12'd50, 12'd200,
               96'hA5_5A_05_00_64_01_2C_00_32_00_C8_90, 3, 100);
    check("overrun drop_cnt", drop_cnt, 8'd3);

    // Strobe in the pkt_sent cycle is accepted; seq 3 shows drops did not advance seq.
    run_packet("back2back", 12'h000, 12'hFFF, 12'h123, 12'h456,
               96'hA5_5A_07_00_00_0F_FF_01_23_04_56_93, 0, 1);
    idle_cycle("back2back");

    // 300 drops: counter saturates while overrun keeps pulsing.
    run_packet("saturate", 12'd100, 12'd300, 12'd50, 12'd200,
               96'hA5_5A_09_00_64_01_2C_00_32_00_C8_94, 300, 4);
    check("saturate drop_cnt", drop_cnt, 8'd255);
    idle_cycle("saturate");

    // Reset during data bit 2 of byte 5 (0x01, so the line is low there).
    xpos_min = 12'd100; xpos_max = 12'd300; ypos_min = 12'd50; ypos_max = 12'd200;
    frame_done = 1'b1;
    @(posedge clk_vga); #1;
    frame_done = 1'b0;
    repeat (CPB * 53 + 1) @(posedge clk_vga);
    #1;
    check("midreset busy_before", busy, 1'b1);
    check("midreset txd_before", uart_txd, 1'b0);
    #2 sys_rst_n = 1'b0;
    #1;
    check("midreset txd_async", uart_txd, 1'b1);
    check("midreset busy_async", busy, 1'b0);
    check("midreset drop_cnt", drop_cnt, 8'd0);
    repeat (3) @(posedge clk_vga);
    @(negedge clk_vga) sys_rst_n = 1'b1;
    @(posedge clk_vga); #1;
    check("postreset txd", uart_txd, 1'b1);
    run_packet("postreset", 12'd100, 12'd300, 12'd50, 12'd200,
               96'hA5_5A_01_00_64_01_2C_00_32_00_C8_8C, 0, 1);
    idle_cycle("postreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
